// File: rtl/vga_pkg.sv
// Shared VGA timing, tile-code and colour constants for the tile renderer.
// Also holds the tile-code to colour lookup used by the last pipeline stage.
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int TILE_SHIFT = 4;
  localparam int GRID_W     = H_ACTIVE >> TILE_SHIFT;
  localparam int GRID_H     = V_ACTIVE >> TILE_SHIFT;
  localparam int TILES      = GRID_W * GRID_H;
  localparam int ADDR_W     = 11;

  typedef logic [1:0]  tile_t;
  typedef logic [11:0] rgb_t;

  localparam tile_t TILE_EMPTY = 2'd0;
  localparam tile_t TILE_BODY  = 2'd1;
  localparam tile_t TILE_HEAD  = 2'd2;
  localparam tile_t TILE_FOOD  = 2'd3;

  localparam rgb_t COL_BLACK = 12'h000;
  localparam rgb_t COL_WALL  = 12'h00F;
  localparam rgb_t COL_BODY  = 12'h0F0;
  localparam rgb_t COL_HEAD  = 12'hFF0;
  localparam rgb_t COL_FOOD  = 12'hF00;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  function automatic rgb_t tile_colour(input tile_t code);
    case (code)
      TILE_BODY: return COL_BODY;
      TILE_HEAD: return COL_HEAD;
      TILE_FOOD: return COL_FOOD;
      default:   return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/tile_renderer_if.sv
// Pixel-side and game-side signals of the tile renderer, grouped for port binding.
// The master drives timing and map writes; the slave is the renderer itself.
interface tile_renderer_if;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hs_in;
  logic        vs_in;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_ready;
  logic        frame_start;
  logic        HS;
  logic        VS;
  logic [3:0]  R;
  logic [3:0]  G;
  logic [3:0]  B;

  modport master (
    output pix_en, hcount, vcount, hs_in, vs_in, wr_en, wr_addr, wr_data,
    input  wr_ready, frame_start, HS, VS, R, G, B
  );

  modport slave (
    input  pix_en, hcount, vcount, hs_in, vs_in, wr_en, wr_addr, wr_data,
    output wr_ready, frame_start, HS, VS, R, G, B
  );
endinterface

// File: rtl/tile_ram.sv
// Single-port tile map: one access per clk, write has priority over read.
// Read data is registered and held on clks without a read.
module tile_ram
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  tile_t             wdata,
  output tile_t             rdata
);

  tile_t mem [TILES];

  // NOTE: the array itself has no reset; the CLEAR sweep initialises it, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= TILE_EMPTY;
    end else if (re && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tile_renderer.sv
// Colour stage behind the VGA sync generator: maps each visible pixel onto the
// 40x30 tile map and drives RGB with HS/VS delayed by the same 3 pix_en stages.
module tile_renderer
  import vga_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  tile_renderer_if.slave  bus
);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_idx, clr_idx_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      ST_CLEAR: begin
        if (clr_idx == ADDR_W'(TILES - 1)) begin
          state_next   = ST_RUN;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + 1'b1;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_CLEAR;
    endcase
  end

  logic wr_ready;
  logic ext_wr;
  logic ext_wr_valid;

  assign wr_ready     = (state == ST_RUN) && (bus.vcount >= 10'(V_ACTIVE));
  assign ext_wr       = bus.wr_en && wr_ready;
  assign ext_wr_valid = ext_wr && (bus.wr_addr < ADDR_W'(TILES));

  assign bus.wr_ready    = wr_ready;
  assign bus.frame_start = (state == ST_RUN) && bus.pix_en &&
                           (bus.hcount == '0) && (bus.vcount == 10'(V_ACTIVE));

  // S1 combinational inputs: tile coordinates of the incoming pixel
  logic [5:0]        col, row;
  logic              active_d, border_d;
  logic [ADDR_W-1:0] addr_d;

  assign col      = 6'(bus.hcount >> TILE_SHIFT);
  assign row      = 6'(bus.vcount >> TILE_SHIFT);
  assign active_d = (bus.hcount < 10'(H_ACTIVE)) && (bus.vcount < 10'(V_ACTIVE));
  assign border_d = (col == '0) || (col == 6'(GRID_W - 1)) ||
                    (row == '0) || (row == 6'(GRID_H - 1));
  assign addr_d   = ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col);

  logic              s1_active, s1_border, s1_hs, s1_vs;
  logic [ADDR_W-1:0] s1_addr;
  logic              s2_active, s2_border, s2_hs, s2_vs;
  rgb_t              rgb_q;
  logic              hs_q, vs_q;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  tile_t             ram_wdata, ram_rdata;

  // Port arbitration: clear sweep, then accepted game writes, else pipeline read
  always_comb begin
    ram_addr  = s1_addr;
    ram_we    = 1'b0;
    ram_wdata = TILE_EMPTY;
    ram_re    = 1'b0;
    if (state == ST_CLEAR) begin
      ram_addr = clr_idx;
      ram_we   = 1'b1;
    end else if (ext_wr) begin
      ram_addr  = bus.wr_addr;
      ram_we    = ext_wr_valid;
      ram_wdata = bus.wr_data;
    end else begin
      ram_re = bus.pix_en;
    end
  end

  tile_ram u_tile_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  rgb_t rgb_d;

  always_comb begin
    rgb_d = COL_BLACK;
    if (state == ST_CLEAR || !s2_active) begin
      rgb_d = COL_BLACK;
    end else if (s2_border) begin
      rgb_d = COL_WALL;
    end else begin
      rgb_d = tile_colour(ram_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_active <= 1'b0;
      s1_border <= 1'b0;
      s1_addr   <= '0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s2_active <= 1'b0;
      s2_border <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      rgb_q     <= COL_BLACK;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else if (bus.pix_en) begin
      s1_active <= active_d;
      s1_border <= border_d;
      s1_addr   <= addr_d;
      s1_hs     <= bus.hs_in;
      s1_vs     <= bus.vs_in;
      s2_active <= s1_active;
      s2_border <= s1_border;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      rgb_q     <= rgb_d;
      hs_q      <= s2_hs;
      vs_q      <= s2_vs;
    end
  end

  assign bus.R  = rgb_q[11:8];
  assign bus.G  = rgb_q[7:4];
  assign bus.B  = rgb_q[3:0];
  assign bus.HS = hs_q;
  assign bus.VS = vs_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Randomised self-checking bench for tile_renderer: a pixel-level reference
// model (tile map array plus a 3-deep output queue) predicts every output.
module tb_tile_renderer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tile_renderer_if bus ();

  tile_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  exp_t pipe_q[$];
  int   model_map [1200];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   obs_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pixel(input int h, input int v);
    int col, row;
    if (h >= 640 || v >= 480) return 12'h000;
    col = h / 16;
    row = v / 16;
    if (col == 0 || col == 39 || row == 0 || row == 29) return 12'h00F;
    case (model_map[row * 40 + col])
      0:       return 12'h000;
      1:       return 12'h0F0;
      2:       return 12'hFF0;
      default: return 12'hF00;
    endcase
  endfunction

  task automatic reset_model();
    exp_t z;
    z = '0;
    pipe_q.delete();
    repeat (3) pipe_q.push_back(z);
    for (int i = 0; i < 1200; i++) model_map[i] = 0;
  endtask

  task automatic drive(input bit pe, input int h, input int v,
                       input bit we = 1'b0, input int wa = 0, input int wd = 0);
    bus.pix_en  = pe;
    bus.hcount  = 10'(h);
    bus.vcount  = 10'(v);
    bus.hs_in   = 1'($urandom_range(0, 1));
    bus.vs_in   = 1'($urandom_range(0, 1));
    bus.wr_en   = we;
    bus.wr_addr = 11'(wa);
    bus.wr_data = 2'(wd);
  endtask

  // One clk: check combinational outputs, clock, then check the pipeline outputs
  task automatic step(input bit run, input bit rgb_forced0);
    exp_t e;
    bit   pe;
    e = '0;
    #1;
    obs_ready = bus.wr_ready;
    check("wr_ready", bus.wr_ready, run && (bus.vcount >= 480));
    check("frame_start", bus.frame_start,
          run && bus.pix_en && (bus.hcount == 0) && (bus.vcount == 480));
    pe = bus.pix_en;
    if (pe) e = '{ref_pixel(int'(bus.hcount), int'(bus.vcount)), bus.hs_in, bus.vs_in};
    if (bus.wr_en && run && bus.vcount >= 480 && bus.wr_addr < 1200)
      model_map[bus.wr_addr] = int'(bus.wr_data);
    @(posedge clk);
    #1;
    if (pe) begin
      pipe_q.push_back(e);
      void'(pipe_q.pop_front());
    end
    check("rgb", {bus.R, bus.G, bus.B}, rgb_forced0 ? 12'h000 : pipe_q[0].rgb);
    check("hs", bus.HS, pipe_q[0].hs);
    check("vs", bus.VS, pipe_q[0].vs);
  endtask

  task automatic reset_and_clear(input int abort_k);
    int first_ready;
    int k;
    int abort_at;
    abort_at = abort_k;
    reset = 1'b1;
    drive(0, 700, 490);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    check("rst_rgb", {bus.R, bus.G, bus.B}, 12'h000);
    check("rst_sync", {bus.HS, bus.VS}, 2'b00);
    check("rst_ready", bus.wr_ready, 1'b0);
    first_ready = -1;
    k = 0;
    while (k < 1204) begin
      if (k == abort_at) begin
        reset = 1'b1;
        drive(0, 700, 490);
        @(posedge clk);
        #1;
        reset = 1'b0;
        reset_model();
        abort_at = -1;
        first_ready = -1;
        k = 0;
        continue;
      end
      if (k == 301)          drive(1, 0, 480);
      else if (k % 2 == 0)   drive(0, $urandom_range(0, 799), 490);
      else if (k < 1100)     drive(1, $urandom_range(0, 639), $urandom_range(0, 479));
      else                   drive(1, 700, 490);
      step(k >= 1200, 1'b1);
      if (k % 2 == 0 && obs_ready && first_ready < 0) first_ready = k;
      k++;
    end
    check("clear_len", first_ready, 1200);
  endtask

  task automatic render_check(input string tag, input int h, input int v, input logic [11:0] exp_rgb);
    logic [1:0] sync;
    drive(1, h, v);
    sync = {bus.hs_in, bus.vs_in};
    step(1'b1, 1'b0);
    drive(1, 700, 490);
    step(1'b1, 1'b0);
    drive(1, 700, 490);
    step(1'b1, 1'b0);
    check(tag, {bus.R, bus.G, bus.B}, exp_rgb);
    check("sync_delay", {bus.HS, bus.VS}, sync);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, v;
    bit we;
    drive(0, 700, 490);
    reset_and_clear(-1);

    // Directed writes: head, food under the wall, blocked, out of range
    drive(0, 100, 490, 1'b1, 41, 2);   step(1'b1, 1'b0);
    drive(0, 100, 490, 1'b1, 0, 3);    step(1'b1, 1'b0);
    drive(0, 100, 200, 1'b1, 100, 1);  step(1'b1, 1'b0);
    drive(0, 100, 495, 1'b1, 1500, 3); step(1'b1, 1'b0);
    render_check("head", 16, 16, 12'hFF0);
    render_check("wall_tl", 0, 0, 12'h00F);
    render_check("wall_br", 639, 479, 12'h00F);
    render_check("blocked_wr", 320, 32, 12'h000);
    render_check("hblank", 700, 16, 12'h000);

    drive(1, 0, 480);
    #1;
    check("fs_pulse", bus.frame_start, 1'b1);
    step(1'b1, 1'b0);
    drive(0, 0, 480);
    #1;
    check("fs_width", bus.frame_start, 1'b0);
    step(1'b1, 1'b0);

    for (int r = 0; r < 3; r++) begin
      repeat (3) begin
        drive(1, 700, 490);
        step(1'b1, 1'b0);
      end
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 2) == 0)
          drive(0, $urandom_range(0, 799), $urandom_range(480, 524), 1'b1,
                $urandom_range(0, 1299), $urandom_range(0, 3));
        else if ($urandom_range(0, 7) == 0)
          drive(1, 0, 480);
        else
          drive(1'($urandom_range(0, 1)), $urandom_range(0, 799), $urandom_range(480, 524));
        step(1'b1, 1'b0);
      end
      for (int i = 0; i < 300; i++) begin
        h  = $urandom_range(0, 799);
        v  = $urandom_range(0, 524);
        we = (v < 480) && ($urandom_range(0, 3) == 0);
        drive(1'($urandom_range(0, 1)), h, v, we, $urandom_range(0, 1199), $urandom_range(0, 3));
        step(1'b1, 1'b0);
      end
    end

    // Reset in RUN with a body tile present, aborted once mid-clear
    repeat (3) begin
      drive(1, 700, 490);
      step(1'b1, 1'b0);
    end
    drive(0, 100, 490, 1'b1, 492, 1);
    step(1'b1, 1'b0);
    render_check("body", 200, 200, 12'h0F0);
    reset_and_clear(600);
    render_check("post_reset", 200, 200, 12'h000);
    for (int i = 0; i < 150; i++) begin
      drive(1, $urandom_range(16, 623), $urandom_range(16, 463));
      step(1'b1, 1'b0);
      check("interior_clear", {bus.R, bus.G, bus.B}, 12'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
